// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_pkg                        |
// | Brief   : shared state encoding and slot-enable helper for the sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_pkg;

   typedef enum logic [1:0] {
      ST_OFF       = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_ON        = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } seq_state_e;

   // Branch k is lit once the pointer has passed it, unless it is excluded.
   function automatic logic slot_en(input int unsigned k, input int unsigned p,
                                    input logic masked);
      return (k < p) && !masked;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_tmr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_tmr                        |
// | Brief   : slot timer, counts 0..STEP-1, wrap marks the last slot cycle   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_tmr #(
   parameter int unsigned STEP = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic wrap
);

   localparam int unsigned     CW     = (STEP > 1) ? $clog2(STEP) : 1;
   localparam logic [CW-1:0]   C_LAST = CW'(STEP - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign wrap = (cnt_q == C_LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkgate_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : gf180mcu_fd_sc_mcu7t5v0__clkgate_seq                            |
// | Brief   : staggered on/off enable sequencer for N clock-buffer branches  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gf180mcu_fd_sc_mcu7t5v0__clkgate_seq
   import gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned STEP = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         REQ,
   input  logic [N-1:0] MASK,
   output logic [N-1:0] BR_EN,
   output logic         ACK,
   output logic         BUSY
);

   localparam int unsigned   PW     = $clog2(N + 1);
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [PW-1:0] P_FULL = PW'(N);

   seq_state_e    state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic [PW-1:0] p_dec;
   logic [N-1:0]  br_en_q, br_en_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic          wrap;
   logic          clr;

   // Saturating decrement; reaching zero is what ends a ramp-down.
   assign p_dec = (p_q > P_ONE) ? (p_q - P_ONE) : '0;

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      case (state_q)
         ST_OFF: begin
            if (REQ) begin
               state_d = ST_RAMP_UP;
               p_d     = P_ONE;
            end
         end
         ST_RAMP_UP: begin
            if (!REQ) begin
               p_d     = p_dec;
               state_d = (p_q <= P_ONE) ? ST_OFF : ST_RAMP_DOWN;
            end else if (wrap) begin
               if (p_q == P_FULL) begin
                  state_d = ST_ON;
               end else begin
                  p_d = p_q + P_ONE;
               end
            end
         end
         ST_ON: begin
            if (!REQ) begin
               p_d     = P_FULL - P_ONE;
               state_d = ST_RAMP_DOWN;
            end
         end
         ST_RAMP_DOWN: begin
            if (REQ) begin
               p_d     = p_q + P_ONE;
               state_d = ST_RAMP_UP;
            end else if (wrap) begin
               p_d = p_dec;
               if (p_q <= P_ONE) begin
                  state_d = ST_OFF;
               end
            end
         end
         default: begin
            state_d = ST_OFF;
            p_d     = '0;
         end
      endcase

      clr    = (state_d != state_q);
      ack_d  = (state_d == ST_ON);
      busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
      for (int unsigned k = 0; k < N; k++) begin
         br_en_d[k] = slot_en(k, 32'(p_d), MASK[k]);
      end
   end

   gf180mcu_fd_sc_mcu7t5v0__clkgate_seq_tmr #(
      .STEP (STEP)
   ) u_tmr (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (clr),
      .wrap (wrap)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_OFF;
         p_q     <= '0;
         br_en_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         br_en_q <= br_en_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign BR_EN = br_en_q;
   assign ACK   = ack_q;
   assign BUSY  = busy_q;

endmodule
`default_nettype wire
